// File: rtl/id_stage_hz.sv
// Decode stage: register file with write-through bypass, control/immediate decode,
// load-use hazard detection and a stall/flush-controlled ID/EX pipeline register.

module control (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic       regwrite_c,
    output logic [1:0] result_src_c,
    output logic       memwrite_c,
    output logic       jump_c,
    output logic       branch_c,
    output logic       alu_src_c,
    output logic [3:0] alu_control_c,
    output logic [2:0] imm_src_c
);
    typedef enum logic [1:0] {ALU_OP_ADD, ALU_OP_SUB, ALU_OP_FUNCT, ALU_OP_LUI} alu_op_e;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;
    localparam logic [2:0] IMM_NONE = 3'd7;

    alu_op_e alu_op;

    // Main decoder
    always_comb begin
        regwrite_c   = 1'b0;
        result_src_c = 2'b00;
        memwrite_c   = 1'b0;
        jump_c       = 1'b0;
        branch_c     = 1'b0;
        alu_src_c    = 1'b0;
        imm_src_c    = IMM_NONE;
        alu_op       = ALU_OP_ADD;
        case (opcode)
            7'h03: begin regwrite_c = 1'b1; result_src_c = 2'b01; alu_src_c = 1'b1; imm_src_c = IMM_I; end
            7'h23: begin memwrite_c = 1'b1; alu_src_c = 1'b1; imm_src_c = IMM_S; end
            7'h33: begin regwrite_c = 1'b1; alu_op = ALU_OP_FUNCT; end
            7'h13: begin regwrite_c = 1'b1; alu_src_c = 1'b1; imm_src_c = IMM_I; alu_op = ALU_OP_FUNCT; end
            7'h63: begin branch_c = 1'b1; imm_src_c = IMM_B; alu_op = ALU_OP_SUB; end
            7'h6F: begin regwrite_c = 1'b1; jump_c = 1'b1; result_src_c = 2'b10; imm_src_c = IMM_J; end
            7'h67: begin
                regwrite_c = 1'b1; jump_c = 1'b1; result_src_c = 2'b10;
                alu_src_c = 1'b1; imm_src_c = IMM_I;
            end
            7'h37: begin regwrite_c = 1'b1; alu_src_c = 1'b1; imm_src_c = IMM_U; alu_op = ALU_OP_LUI; end
            default: ;
        endcase
    end

    // ALU decoder; subtract only for register-register ops (opcode bit 5)
    always_comb begin
        alu_control_c = 4'd0;
        case (alu_op)
            ALU_OP_SUB: alu_control_c = 4'd1;
            ALU_OP_LUI: alu_control_c = 4'd10;
            ALU_OP_FUNCT: begin
                case (funct3)
                    3'd0:    alu_control_c = (opcode[5] && funct7_5) ? 4'd1 : 4'd0;
                    3'd1:    alu_control_c = 4'd7;
                    3'd2:    alu_control_c = 4'd5;
                    3'd3:    alu_control_c = 4'd6;
                    3'd4:    alu_control_c = 4'd4;
                    3'd5:    alu_control_c = funct7_5 ? 4'd9 : 4'd8;
                    3'd6:    alu_control_c = 4'd3;
                    default: alu_control_c = 4'd2;
                endcase
            end
            default: alu_control_c = 4'd0;
        endcase
    end
endmodule

module imm_gen (
    input  logic [31:0] instr,
    input  logic [2:0]  imm_src,
    output logic [31:0] imm_c
);
    always_comb begin
        imm_c = '0;
        case (imm_src)
            3'd0: imm_c = {{20{instr[31]}}, instr[31:20]};
            3'd1: imm_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'd2: imm_c = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            3'd3: imm_c = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            3'd4: imm_c = {instr[31:12], 12'h000};
            default: imm_c = '0;
        endcase
    end
endmodule

module id_stage_hz #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_plus_4,
    input  logic            if_id_valid,
    input  logic            writeback_control,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] writeback_data,
    input  logic            stall_d,
    input  logic            flush_e,
    output logic            load_use_stall,
    output logic [XLEN-1:0] immediate,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] id_ex_pc,
    output logic [XLEN-1:0] id_ex_pc_plus_4,
    output logic [4:0]      rs1_out,
    output logic [4:0]      rs2_out,
    output logic [4:0]      rd_out,
    output logic            regwrite_d,
    output logic            memwrite_d,
    output logic            jump_d,
    output logic            branch_d,
    output logic            alu_src_d,
    output logic [1:0]      result_src_d,
    output logic [3:0]      alu_control_d,
    output logic            valid_e,
    output logic            illegal_reg_e
);
    localparam int unsigned IW      = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [5:0]  NREGS_L = 6'(NREGS);

    typedef struct packed {
        logic [XLEN-1:0] immediate;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus_4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            regwrite;
        logic            memwrite;
        logic            jump;
        logic            branch;
        logic            alu_src;
        logic [1:0]      result_src;
        logic [3:0]      alu_control;
        logic            valid;
        logic            illegal_reg;
    } id_ex_t;

    function automatic logic in_range(input logic [4:0] idx);
        return {1'b0, idx} < NREGS_L;
    endfunction

    logic [XLEN-1:0] regs [NREGS];
    logic [4:0]      rs1_idx, rs2_idx, rd_idx;
    logic [XLEN-1:0] rs1_val_c, rs2_val_c;
    logic            ctl_regwrite_c, ctl_memwrite_c, ctl_jump_c, ctl_branch_c, ctl_alu_src_c;
    logic [1:0]      ctl_result_src_c;
    logic [3:0]      ctl_alu_control_c;
    logic [2:0]      imm_src_c;
    logic [31:0]     imm32_c;
    logic            illegal_reg_d;
    id_ex_t          id_ex_q, id_ex_nxt;

    assign rs1_idx = instruction[19:15];
    assign rs2_idx = instruction[24:20];
    assign rd_idx  = instruction[11:7];

    control u_control (
        .opcode        (instruction[6:0]),
        .funct3        (instruction[14:12]),
        .funct7_5      (instruction[30]),
        .regwrite_c    (ctl_regwrite_c),
        .result_src_c  (ctl_result_src_c),
        .memwrite_c    (ctl_memwrite_c),
        .jump_c        (ctl_jump_c),
        .branch_c      (ctl_branch_c),
        .alu_src_c     (ctl_alu_src_c),
        .alu_control_c (ctl_alu_control_c),
        .imm_src_c     (imm_src_c)
    );

    imm_gen u_imm_gen (
        .instr   (instruction),
        .imm_src (imm_src_c),
        .imm_c   (imm32_c)
    );

    // Register file; x0 and out-of-range indices are never written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
        end else if (writeback_control && rd != 5'd0 && in_range(rd)) begin
            regs[rd[IW-1:0]] <= writeback_data;
        end
    end

    // Read ports with write-through bypass from the current writeback
    always_comb begin
        rs1_val_c = '0;
        if (rs1_idx != 5'd0 && in_range(rs1_idx)) begin
            if (writeback_control && rd == rs1_idx) rs1_val_c = writeback_data;
            else                                    rs1_val_c = regs[rs1_idx[IW-1:0]];
        end
    end

    always_comb begin
        rs2_val_c = '0;
        if (rs2_idx != 5'd0 && in_range(rs2_idx)) begin
            if (writeback_control && rd == rs2_idx) rs2_val_c = writeback_data;
            else                                    rs2_val_c = regs[rs2_idx[IW-1:0]];
        end
    end

    assign illegal_reg_d = if_id_valid &&
                           (!in_range(rs1_idx) || !in_range(rs2_idx) || !in_range(rd_idx));

    assign load_use_stall = if_id_valid && id_ex_q.valid && id_ex_q.regwrite &&
                            id_ex_q.result_src == 2'b01 && id_ex_q.rd != 5'd0 &&
                            (id_ex_q.rd == rs1_idx || id_ex_q.rd == rs2_idx);

    // Next ID/EX contents: a bubble unless a real, hazard-free instruction is decoding
    always_comb begin
        id_ex_nxt = '0;
        if (!flush_e && !load_use_stall && if_id_valid) begin
            id_ex_nxt.immediate   = XLEN'($signed(imm32_c));
            id_ex_nxt.rs1_data    = rs1_val_c;
            id_ex_nxt.rs2_data    = rs2_val_c;
            id_ex_nxt.pc          = pc;
            id_ex_nxt.pc_plus_4   = pc_plus_4;
            id_ex_nxt.rs1         = rs1_idx;
            id_ex_nxt.rs2         = rs2_idx;
            id_ex_nxt.rd          = rd_idx;
            id_ex_nxt.regwrite    = ctl_regwrite_c && !illegal_reg_d;
            id_ex_nxt.memwrite    = ctl_memwrite_c && !illegal_reg_d;
            id_ex_nxt.jump        = ctl_jump_c;
            id_ex_nxt.branch      = ctl_branch_c;
            id_ex_nxt.alu_src     = ctl_alu_src_c;
            id_ex_nxt.result_src  = ctl_result_src_c;
            id_ex_nxt.alu_control = ctl_alu_control_c;
            id_ex_nxt.valid       = 1'b1;
            id_ex_nxt.illegal_reg = illegal_reg_d;
        end
    end

    // Flush overrides the hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                     id_ex_q <= '0;
        else if (flush_e || !stall_d)  id_ex_q <= id_ex_nxt;
    end

    assign immediate       = id_ex_q.immediate;
    assign rs1_data        = id_ex_q.rs1_data;
    assign rs2_data        = id_ex_q.rs2_data;
    assign id_ex_pc        = id_ex_q.pc;
    assign id_ex_pc_plus_4 = id_ex_q.pc_plus_4;
    assign rs1_out         = id_ex_q.rs1;
    assign rs2_out         = id_ex_q.rs2;
    assign rd_out          = id_ex_q.rd;
    assign regwrite_d      = id_ex_q.regwrite;
    assign memwrite_d      = id_ex_q.memwrite;
    assign jump_d          = id_ex_q.jump;
    assign branch_d        = id_ex_q.branch;
    assign alu_src_d       = id_ex_q.alu_src;
    assign result_src_d    = id_ex_q.result_src;
    assign alu_control_d   = id_ex_q.alu_control;
    assign valid_e         = id_ex_q.valid;
    assign illegal_reg_e   = id_ex_q.illegal_reg;
endmodule

// File: tb/tb_id_stage_hz.sv
// Bench for id_stage_hz (XLEN=64, NREGS=16): directed hazard scenarios plus random
// traffic compared against an instruction-level reference model.

module tb_id_stage_hz;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned NREGS = 16;
    localparam logic [6:0]  OPS [8] = '{7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h7F};

    typedef logic [XLEN-1:0] word_t;
    typedef struct packed {
        word_t      imm, rs1d, rs2d, pc, pc4;
        logic [4:0] rs1, rs2, rd;
        logic       regw, memw, jump, branch, alusrc;
        logic [1:0] rsrc;
        logic [3:0] aluc;
        logic       valid, illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    word_t       pc, pc_plus_4, writeback_data;
    logic        if_id_valid, writeback_control, stall_d, flush_e;
    logic [4:0]  rd;
    logic        load_use_stall;
    word_t       immediate, rs1_data, rs2_data, id_ex_pc, id_ex_pc_plus_4;
    logic [4:0]  rs1_out, rs2_out, rd_out;
    logic        regwrite_d, memwrite_d, jump_d, branch_d, alu_src_d, valid_e, illegal_reg_e;
    logic [1:0]  result_src_d;
    logic [3:0]  alu_control_d;

    exp_t  exp_q;
    word_t mrf [32];
    int    n_checks = 0;
    int    n_pass   = 0;
    logic  lu, hold;

    always #5 clk = ~clk;

    id_stage_hz #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .pc(pc), .pc_plus_4(pc_plus_4),
        .if_id_valid(if_id_valid), .writeback_control(writeback_control), .rd(rd),
        .writeback_data(writeback_data), .stall_d(stall_d), .flush_e(flush_e),
        .load_use_stall(load_use_stall), .immediate(immediate), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .id_ex_pc(id_ex_pc), .id_ex_pc_plus_4(id_ex_pc_plus_4),
        .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out), .regwrite_d(regwrite_d),
        .memwrite_d(memwrite_d), .jump_d(jump_d), .branch_d(branch_d), .alu_src_d(alu_src_d),
        .result_src_d(result_src_d), .alu_control_d(alu_control_d), .valid_e(valid_e),
        .illegal_reg_e(illegal_reg_e)
    );

    task automatic check(input string tag, input word_t got, input word_t want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    endtask

    // ALU operation codes: add0 sub1 and2 or3 xor4 slt5 sltu6 sll7 srl8 sra9 lui10
    function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic is_r, input logic b30);
        case (f3)
            3'd0:    return (is_r && b30) ? 4'd1 : 4'd0;
            3'd1:    return 4'd7;
            3'd2:    return 4'd5;
            3'd3:    return 4'd6;
            3'd4:    return 4'd4;
            3'd5:    return b30 ? 4'd9 : 4'd8;
            3'd6:    return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic exp_t decode(input logic [31:0] ins);
        exp_t e;
        e = '0;
        case (ins[6:0])
            7'h03: begin e.regw = 1; e.rsrc = 2'b01; e.alusrc = 1; e.imm = word_t'($signed(ins[31:20])); end
            7'h23: begin e.memw = 1; e.alusrc = 1; e.imm = word_t'($signed({ins[31:25], ins[11:7]})); end
            7'h33: begin e.regw = 1; e.aluc = alu_fn(ins[14:12], 1'b1, ins[30]); end
            7'h13: begin
                e.regw = 1; e.alusrc = 1; e.aluc = alu_fn(ins[14:12], 1'b0, ins[30]);
                e.imm = word_t'($signed(ins[31:20]));
            end
            7'h63: begin
                e.branch = 1; e.aluc = 4'd1;
                e.imm = word_t'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            end
            7'h6F: begin
                e.regw = 1; e.jump = 1; e.rsrc = 2'b10;
                e.imm = word_t'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            end
            7'h67: begin
                e.regw = 1; e.jump = 1; e.rsrc = 2'b10; e.alusrc = 1;
                e.imm = word_t'($signed(ins[31:20]));
            end
            7'h37: begin e.regw = 1; e.alusrc = 1; e.aluc = 4'd10; e.imm = word_t'($signed({ins[31:12], 12'h000})); end
            default: ;
        endcase
        return e;
    endfunction

    function automatic word_t rf_read(input logic [4:0] idx);
        if (idx == 5'd0 || int'(idx) >= int'(NREGS)) return '0;
        if (writeback_control && rd == idx) return writeback_data;
        return mrf[idx];
    endfunction

    function automatic exp_t capture();
        exp_t e;
        logic ill;
        e = decode(instruction);
        e.rs1 = instruction[19:15];
        e.rs2 = instruction[24:20];
        e.rd  = instruction[11:7];
        e.rs1d = rf_read(e.rs1);
        e.rs2d = rf_read(e.rs2);
        e.pc = pc;
        e.pc4 = pc_plus_4;
        e.valid = 1'b1;
        ill = int'(e.rs1) >= int'(NREGS) || int'(e.rs2) >= int'(NREGS) || int'(e.rd) >= int'(NREGS);
        e.illegal = ill;
        if (ill) begin e.regw = 1'b0; e.memw = 1'b0; end
        return e;
    endfunction

    function automatic logic model_lu();
        return if_id_valid && exp_q.valid && exp_q.regw && exp_q.rsrc == 2'b01 && exp_q.rd != 5'd0 &&
               (exp_q.rd == instruction[19:15] || exp_q.rd == instruction[24:20]);
    endfunction

    task automatic check_outputs();
        check("immediate", immediate, exp_q.imm);
        check("rs1_data", rs1_data, exp_q.rs1d);
        check("rs2_data", rs2_data, exp_q.rs2d);
        check("id_ex_pc", id_ex_pc, exp_q.pc);
        check("id_ex_pc_plus_4", id_ex_pc_plus_4, exp_q.pc4);
        check("rs1_out", word_t'(rs1_out), word_t'(exp_q.rs1));
        check("rs2_out", word_t'(rs2_out), word_t'(exp_q.rs2));
        check("rd_out", word_t'(rd_out), word_t'(exp_q.rd));
        check("regwrite_d", word_t'(regwrite_d), word_t'(exp_q.regw));
        check("memwrite_d", word_t'(memwrite_d), word_t'(exp_q.memw));
        check("jump_d", word_t'(jump_d), word_t'(exp_q.jump));
        check("branch_d", word_t'(branch_d), word_t'(exp_q.branch));
        check("alu_src_d", word_t'(alu_src_d), word_t'(exp_q.alusrc));
        check("result_src_d", word_t'(result_src_d), word_t'(exp_q.rsrc));
        check("alu_control_d", word_t'(alu_control_d), word_t'(exp_q.aluc));
        check("valid_e", word_t'(valid_e), word_t'(exp_q.valid));
        check("illegal_reg_e", word_t'(illegal_reg_e), word_t'(exp_q.illegal));
    endtask

    // One cycle: inputs are already driven; checks the hazard flag, clocks, checks ID/EX
    task automatic step(output logic lu_o);
        exp_t nxt;
        #1;
        lu_o = model_lu();
        check("load_use_stall", word_t'(load_use_stall), word_t'(lu_o));
        if (flush_e)                      nxt = '0;
        else if (stall_d)                 nxt = exp_q;
        else if (lu_o || !if_id_valid)    nxt = '0;
        else                              nxt = capture();
        if (writeback_control && rd != 5'd0 && int'(rd) < int'(NREGS)) mrf[rd] = writeback_data;
        @(posedge clk);
        #1;
        exp_q = nxt;
        check_outputs();
    endtask

    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        exp_q = '0;
        for (int i = 0; i < 32; i++) mrf[i] = '0;
        check_outputs();
        check("reset_load_use", word_t'(load_use_stall), '0);
        @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
        return {7'h00, s2, s1, 3'b000, d, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] d,
                                          input logic [4:0] s1, input logic [11:0] imm);
        return {imm, s1, f3, d, op};
    endfunction

    function automatic logic [4:0] rnd_reg();
        if ($urandom_range(0, 7) == 0) return 5'($urandom_range(16, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        w = $urandom;
        w[6:0]   = ($urandom_range(0, 2) == 0) ? 7'h03 : OPS[$urandom_range(0, 7)];
        w[11:7]  = rnd_reg();
        w[19:15] = rnd_reg();
        w[24:20] = rnd_reg();
        return w;
    endfunction

    task automatic drive(input logic [31:0] ins, input logic wb, input logic [4:0] wrd, input word_t wdata);
        instruction = ins;
        pc = pc + 64'd4;
        pc_plus_4 = pc + 64'd4;
        if_id_valid = 1'b1;
        writeback_control = wb;
        rd = wrd;
        writeback_data = wdata;
        stall_d = 1'b0;
        flush_e = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        instruction = '0; pc = 64'h1000; pc_plus_4 = 64'h1004; if_id_valid = 1'b0;
        writeback_control = 1'b0; rd = '0; writeback_data = '0; stall_d = 1'b0; flush_e = 1'b0;
        exp_q = '0;
        for (int i = 0; i < 32; i++) mrf[i] = '0;
        #3;
        check_outputs();
        check("reset_load_use", word_t'(load_use_stall), '0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // x0 ignores writes and always reads zero
        drive(enc_r(5'd1, 5'd0, 5'd0), 1'b1, 5'd0, 64'hDEAD);
        step(lu);
        check("x0_read_bypass", rs1_data, '0);
        drive(enc_r(5'd1, 5'd0, 5'd0), 1'b0, 5'd0, '0);
        step(lu);
        check("x0_read_stored", rs1_data, '0);

        // Same-cycle writeback reaches the decoding instruction
        drive(enc_i(7'h13, 3'b000, 5'd6, 5'd5, 12'd7), 1'b1, 5'd5, 64'h1234);
        step(lu);
        check("bypass_rs1", rs1_data, 64'h1234);
        check("bypass_imm", immediate, 64'd7);
        check("bypass_valid", word_t'(valid_e), 64'd1);

        // Load-use: one bubble, then the dependent add captures
        drive(enc_i(7'h03, 3'b010, 5'd3, 5'd2, 12'd0), 1'b0, 5'd0, '0);
        step(lu);
        drive(enc_r(5'd4, 5'd3, 5'd1), 1'b0, 5'd0, '0);
        #1;
        check("hazard_stall", word_t'(load_use_stall), 64'd1);
        step(lu);
        check("hazard_bubble_valid", word_t'(valid_e), '0);
        check("hazard_bubble_regw", word_t'(regwrite_d), '0);
        pc_plus_4 = pc + 64'd4;
        step(lu);
        check("hazard_after_rs1", word_t'(rs1_out), 64'd3);
        check("hazard_after_valid", word_t'(valid_e), 64'd1);

        // A load to x0 never stalls
        drive(enc_i(7'h03, 3'b010, 5'd0, 5'd2, 12'd0), 1'b0, 5'd0, '0);
        step(lu);
        drive(enc_r(5'd4, 5'd0, 5'd1), 1'b0, 5'd0, '0);
        #1;
        check("x0_load_no_stall", word_t'(load_use_stall), '0);
        step(lu);

        // Hold for three cycles, then flush beats stall
        drive(enc_i(7'h13, 3'b000, 5'd7, 5'd1, 12'd5), 1'b0, 5'd0, '0);
        step(lu);
        for (int k = 0; k < 3; k++) begin
            drive(rnd_instr(), 1'b0, 5'd0, '0);
            stall_d = 1'b1;
            step(lu);
            check("stall_hold_rd", word_t'(rd_out), 64'd7);
        end
        drive(rnd_instr(), 1'b0, 5'd0, '0);
        stall_d = 1'b1;
        flush_e = 1'b1;
        step(lu);
        check("flush_stall_valid", word_t'(valid_e), '0);
        check("flush_stall_rd", word_t'(rd_out), '0);

        // Register indices beyond NREGS
        drive(enc_i(7'h13, 3'b000, 5'd20, 5'd1, 12'd1), 1'b0, 5'd0, '0);
        step(lu);
        check("illegal_flag", word_t'(illegal_reg_e), 64'd1);
        check("illegal_regw", word_t'(regwrite_d), '0);
        drive(enc_r(5'd5, 5'd20, 5'd0), 1'b1, 5'd20, 64'hBEEF);
        step(lu);
        check("x20_bypass_zero", rs1_data, '0);
        drive(enc_r(5'd5, 5'd20, 5'd0), 1'b0, 5'd0, '0);
        step(lu);
        check("x20_read_zero", rs1_data, '0);

        // Random traffic; fetch holds IF/ID while a load-use stall is flagged
        hold = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                async_reset();
                hold = 1'b0;
            end
            if (!hold) begin
                instruction = rnd_instr();
                pc = word_t'({$urandom, $urandom});
                pc_plus_4 = pc + 64'd4;
                if_id_valid = ($urandom_range(0, 7) != 0);
            end
            writeback_control = 1'($urandom_range(0, 1));
            rd = rnd_reg();
            writeback_data = word_t'({$urandom, $urandom});
            stall_d = ($urandom_range(0, 7) == 0);
            flush_e = ($urandom_range(0, 9) == 0);
            step(lu);
            hold = lu;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
